// File: rtl/flow_speed_pkg.sv
// Shared types for the ingress packet checker: FSM states, error reasons and
// the stream byte-width helper.
package flow_speed_pkg;

  typedef enum logic [1:0] {
    FIRST,
    BODY,
    DISCARD
  } chk_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MTY,
    ERR_SHORT,
    ERR_LONG
  } err_e;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream slice: a main output register backed by one
// skid entry, with a registered input ready so neither side sees a comb path.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             ready_q;
  logic             in_fire;

  assign in_fire   = in_valid & ready_q;
  assign in_ready  = ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (!main_v_q || out_ready) begin
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = in_fire;
        if (in_fire) main_d = in_data;
      end
    end else if (in_fire) begin
      skid_v_d = 1'b1;
      skid_d   = in_data;
    end
  end

  // ready is held low during reset and only depends on skid occupancy afterwards
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      main_v_q <= 1'b0;
      main_q   <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      ready_q  <= !skid_v_d;
    end
  end

endmodule

// File: rtl/axis_pkt_checker.sv
// Ingress packet checker: forwards the stream, flags bad packets on their last
// output beat, truncates over-long packets and counts good/bad packets.
//
//   state   | meaning
//   FIRST   | waiting for the first beat of a packet
//   BODY    | inside a packet, length accumulating
//   DISCARD | packet truncated at MAX_LEN, swallowing its tail
module axis_pkt_checker
  import flow_speed_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MTY_WIDTH  = 8,
  parameter int MIN_LEN    = 4,
  parameter int MAX_LEN    = 1518,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [MTY_WIDTH-1:0]  s_axis_tuser_mty,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [MTY_WIDTH-1:0]  m_axis_tuser_mty,
  input  logic                  m_axis_tready,
  output logic                  drop_incmpt_pkt,
  output logic [CNT_WIDTH-1:0]  good_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  bad_pkt_cnt
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int LEN_W = $clog2(MAX_LEN + 1) + 1;
  localparam int PW    = DATA_WIDTH + MTY_WIDTH + 2;

  chk_state_e           state_q, state_d;
  err_e                 err;
  logic [LEN_W-1:0]     beats_q, beats_d, beats_cur, len_cur, len_final;
  logic                 in_fire, trunc, fwd_valid, fwd_last, fwd_drop;
  logic [MTY_WIDTH-1:0] fwd_mty;
  logic [PW-1:0]        fwd_payload, out_payload;
  logic                 out_drop, out_fire_last;

  assign in_fire = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    err       = ERR_NONE;
    trunc     = 1'b0;
    beats_cur = (state_q == FIRST) ? LEN_W'(1) : beats_q + LEN_W'(1);
    len_cur   = beats_cur * LEN_W'(BYTES);
    len_final = len_cur - LEN_W'(s_axis_tuser_mty);

    if (in_fire) begin
      case (state_q)
        FIRST: begin
          if (!s_axis_tlast) begin
            state_d = BODY;
            beats_d = beats_cur;
          end
        end
        BODY: begin
          if (s_axis_tlast) begin
            state_d = FIRST;
          end else if (len_cur == LEN_W'(MAX_LEN)) begin
            state_d = DISCARD;
            trunc   = 1'b1;
          end else begin
            beats_d = beats_cur;
          end
        end
        DISCARD: begin
          if (s_axis_tlast) state_d = FIRST;
        end
        default: state_d = FIRST;
      endcase
    end

    // mty is checked first: it also guards len_final against underflow
    if (trunc) begin
      err = ERR_LONG;
    end else if (s_axis_tlast) begin
      if (s_axis_tuser_mty >= MTY_WIDTH'(BYTES)) err = ERR_MTY;
      else if (len_final < LEN_W'(MIN_LEN))      err = ERR_SHORT;
    end
  end

  assign fwd_valid   = in_fire && (state_q != DISCARD);
  assign fwd_last    = s_axis_tlast | trunc;
  assign fwd_mty     = trunc ? '0 : s_axis_tuser_mty;
  assign fwd_drop    = (err != ERR_NONE);
  assign fwd_payload = {s_axis_tdata, fwd_last, fwd_mty, fwd_drop};

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q <= FIRST;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .aclk      (aclk),
    .areset    (areset),
    .in_valid  (fwd_valid),
    .in_data   (fwd_payload),
    .in_ready  (s_axis_tready),
    .out_valid (m_axis_tvalid),
    .out_data  (out_payload),
    .out_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty, out_drop} = out_payload;

  assign out_fire_last   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign drop_incmpt_pkt = out_fire_last & out_drop;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      good_pkt_cnt <= '0;
      bad_pkt_cnt  <= '0;
    end else if (out_fire_last) begin
      if (out_drop) begin
        if (bad_pkt_cnt != '1) bad_pkt_cnt <= bad_pkt_cnt + 1'b1;
      end else begin
        if (good_pkt_cnt != '1) good_pkt_cnt <= good_pkt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_pkt_checker.md
# axis_pkt_checker

Ingress packet checker placed directly upstream of the packet `queue`. It forwards an AXI-Stream packet flow and computes each packet's byte length. Packets that are too short, too long or carry an illegal `mty` are flagged by asserting `drop_incmpt_pkt` on their last output beat, so the `queue` discards them. Over-long packets are truncated at `MAX_LEN` and their tail is swallowed; good and bad packet counts are exported for the flow-speed statistics.

## Interface
- `DATA_WIDTH`, 8: stream data width in bits, a multiple of 8. BYTES = DATA_WIDTH/8.
- `MTY_WIDTH`, 8: width of the `tuser_mty` field.
- `MIN_LEN`, 4: minimum legal packet length in bytes.
- `MAX_LEN`, 1518: maximum legal packet length in bytes. Must be a multiple of BYTES and ≥ MIN_LEN.
- `CNT_WIDTH`, 32: width of the statistics counters.
- `aclk` in 1: clock; all logic is on its rising edge.
- `areset` in 1: reset, asynchronous assert, active-low (0 = reset). Deassertion is synchronised to `aclk`.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tdata` in DATA_WIDTH: input data.
- `s_axis_tlast` in 1: input last beat of packet.
- `s_axis_tuser_mty` in MTY_WIDTH: number of empty bytes in the last beat. Ignored when `s_axis_tlast`=0.
- `s_axis_tready` out 1: input ready.
- `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`, `m_axis_tuser_mty` out (1, DATA_WIDTH, 1, MTY_WIDTH): forwarded stream.
- `m_axis_tready` in 1: downstream ready.
- `drop_incmpt_pkt` out 1: packet-bad flag. Meaningful only when `m_axis_tvalid`, `m_axis_tlast` and `m_axis_tready` are all 1; 0 at all other times.
- `good_pkt_cnt` out CNT_WIDTH: count of packets passed as good; saturating.
- `bad_pkt_cnt` out CNT_WIDTH: count of packets flagged bad; saturating.

## Operation
- An input beat is accepted when `s_axis_tvalid` and `s_axis_tready` are both 1. The beat counter `beats` increments once per accepted beat.
- Running byte length: `len` = beats×BYTES. Add one bit of headroom so `len` cannot overflow before the MAX_LEN compare.
- On an accepted tlast beat, the final length is `len` − mty.
- State machine (states live in the shared package):
  - **FIRST**, the reset state. An accepted beat goes to BODY. An accepted tlast beat stays in FIRST and is evaluated immediately.
  - **BODY**. An accepted tlast beat evaluates the packet and returns to FIRST. If an accepted non-tlast beat makes `len` equal MAX_LEN, the block truncates: the output beat gets `tlast` forced to 1, `mty` forced to 0 and `drop_incmpt_pkt`=1, and the state moves to DISCARD.
  - **DISCARD**. Input is accepted (`s_axis_tready` follows local space) and nothing is forwarded. An accepted tlast beat returns to FIRST.
- Bad conditions, each of which sets drop=1 on the output tlast beat:
  - `mty` ≥ BYTES;
  - final length < MIN_LEN;
  - truncation.
- Counters increment once per packet, when its tlast beat is accepted at the output. A truncated packet counts as bad exactly once; its discarded tail is not counted again.
- `m_axis_tdata` and `m_axis_tuser_mty` pass through unmodified, except `mty` on a truncation beat.

## Timing
- Exactly 1 cycle of latency from input acceptance to `m_axis_tvalid`, through a registered output stage backed by a 2-entry skid buffer.
- Full throughput: one beat per cycle with `m_axis_tready`=1.
- `s_axis_tready` is registered: it is 0 only when the skid entry is occupied.
- When `m_axis_tvalid`=1 and `m_axis_tready`=0, all m-side outputs stay stable until the beat is accepted.
- Reset values, held while `areset`=0:
  - `s_axis_tready`=0, `m_axis_tvalid`=0, all m-side data and `drop_incmpt_pkt` = 0;
  - both counters 0;
  - state FIRST.
- `s_axis_tready` rises on the first clock edge after reset is released.
- Reset mid-packet: the partial packet is lost and is not counted. The next accepted beat is treated as a packet start.
- A tlast beat that also hits MAX_LEN in BODY is a normal end of packet, judged by the length rules. It is not a truncation.
- Counters hold at the all-ones value when saturated.

## Structure
- Shared package `flow_speed_pkg`:
  - the state enum (FIRST/BODY/DISCARD);
  - an error-reason enum (NONE, MTY, SHORT, LONG) used internally and for assertions;
  - a function giving BYTES from DATA_WIDTH.
- One sub-module, `axis_skid_buffer`: a 2-entry registered slice carrying {data, last, mty, drop}, parameterised by payload width.
- The checker FSM, length arithmetic and counters sit in the top level.

## Test plan
All scenarios use DATA_WIDTH=8 (BYTES=1), MIN_LEN=4 and MAX_LEN=16.
- Good packet: 12 beats 0x01..0x0C, mty=0, `m_axis_tready`=1 → identical 12 beats out, each 1 cycle late; drop=0 on beat 0x0C; `good_pkt_cnt`=1.
- Illegal mty: 12 beats with mty=1 on the last beat → all 12 beats forwarded, mty=1 passed through, drop=1 on the last beat; `bad_pkt_cnt`=1.
- Short packet: 3 beats 0x01..0x03 with tlast on 0x03 → 3 beats out, drop=1; back-to-back 1-beat packets are each flagged.
- Truncation: 20 beats 0x01..0x14, tlast on 0x14 → 16 beats out with tlast forced on 0x10 and drop=1; beats 0x11..0x14 are accepted and not forwarded; `bad_pkt_cnt` increments by exactly 1.
- Backpressure: drive `m_axis_tready` low for 2 cycles mid-packet with continuous input → `s_axis_tready` falls within 1 cycle of the stall; no beat is lost or duplicated and outputs stay stable while stalled.
- Reset: assert `areset`=0 after beat 5 of a 12-beat packet → outputs and counters go to 0 immediately; after release, a new good 12-beat packet gives `good_pkt_cnt`=1.
